// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding and the held request.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'b00,
        ArbGntD = 2'b01,
        ArbGntI = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_req_t;

    localparam logic [3:0] InstSel = 4'b1111;

    // Instruction fetches are always full-word reads.
    function automatic ram_req_t inst_req(input logic [31:0] addr);
        ram_req_t r;
        r.we    = 1'b0;
        r.sel   = InstSel;
        r.addr  = addr;
        r.wdata = 32'h0;
        return r;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction fetch and the data cache; data has priority,
// a starvation counter guarantees fetch progress and a timeout aborts stuck grants.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_ready_o,

    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ready_o,

    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_data_ready_i,

    output logic        bus_err_o
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e         state_q, state_d;
    ram_req_t           req_q, req_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               inst_ready_q, inst_ready_d;
    logic               data_ready_q, data_ready_d;
    logic [31:0]        inst_rdata_q, inst_rdata_d;
    logic [31:0]        data_rdata_q, data_rdata_d;
    logic               bus_err_q, bus_err_d;

    logic        inst_pend, data_pend, inst_wins, starved;
    logic        expire, finish, keep_rdata;
    logic [31:0] rdata_val;

    // A requester whose ready pulse is out this cycle still holds its request; ignore it.
    assign inst_pend = inst_req_i & ~inst_ready_q;
    assign data_pend = data_ce_i & ~data_ready_q;
    assign starved   = (starve_q == StarveW'(STARVE_LIMIT));
    assign inst_wins = inst_pend & (~data_pend | starved);

    // Normal completion takes precedence over a coincident timeout.
    assign expire     = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign finish     = ram_data_ready_i | expire;
    assign rdata_val  = ram_data_ready_i ? ram_data_i : 32'h0;
    assign keep_rdata = ram_data_ready_i & req_q.we;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        starve_d     = starve_q;
        tmo_d        = tmo_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_err_d    = 1'b0;

        unique case (state_q)
            ArbIdle: begin
                tmo_d = '0;
                if (inst_wins) begin
                    state_d  = ArbGntI;
                    req_d    = inst_req(inst_addr_i);
                    starve_d = '0;
                end else if (data_pend) begin
                    state_d     = ArbGntD;
                    req_d.we    = data_we_i;
                    req_d.sel   = data_sel_i;
                    req_d.addr  = data_addr_i;
                    req_d.wdata = data_wdata_i;
                    if (inst_req_i && !starved) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end
            end
            ArbGntD, ArbGntI: begin
                if (finish) begin
                    state_d   = ArbIdle;
                    tmo_d     = '0;
                    bus_err_d = ~ram_data_ready_i;
                    if (state_q == ArbGntD) begin
                        data_ready_d = 1'b1;
                        if (!keep_rdata) data_rdata_d = rdata_val;
                    end else begin
                        inst_ready_d = 1'b1;
                        if (!keep_rdata) inst_rdata_d = rdata_val;
                    end
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ArbIdle;
            req_q        <= '0;
            starve_q     <= '0;
            tmo_q        <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            starve_q     <= starve_d;
            tmo_q        <= tmo_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign ram_ce_o     = (state_q != ArbIdle);
    assign ram_we_o     = ram_ce_o & req_q.we;
    assign ram_sel_o    = req_q.sel;
    assign ram_addr_o   = req_q.addr;
    assign ram_data_o   = req_q.wdata;
    assign inst_data_o  = inst_rdata_q;
    assign inst_ready_o = inst_ready_q;
    assign data_rdata_o = data_rdata_q;
    assign data_ready_o = data_ready_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (STARVE_LIMIT=2, TIMEOUT_CYCLES=8).
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_ready_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;
    logic        ram_data_ready_i;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;

    ram_arbiter #(
        .STARVE_LIMIT  (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req_i      (inst_req_i),
        .inst_addr_i     (inst_addr_i),
        .inst_data_o     (inst_data_o),
        .inst_ready_o    (inst_ready_o),
        .data_ce_i       (data_ce_i),
        .data_we_i       (data_we_i),
        .data_sel_i      (data_sel_i),
        .data_addr_i     (data_addr_i),
        .data_wdata_i    (data_wdata_i),
        .data_rdata_o    (data_rdata_o),
        .data_ready_o    (data_ready_o),
        .ram_ce_o        (ram_ce_o),
        .ram_we_o        (ram_we_o),
        .ram_sel_o       (ram_sel_o),
        .ram_addr_o      (ram_addr_o),
        .ram_data_o      (ram_data_o),
        .ram_data_i      (ram_data_i),
        .ram_data_ready_i(ram_data_ready_i),
        .bus_err_o       (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and samples sit 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        inst_req_i = 1'b0; inst_addr_i = '0;
        data_ce_i = 1'b0; data_we_i = 1'b0; data_sel_i = '0;
        data_addr_i = '0; data_wdata_i = '0;
        ram_data_i = '0; ram_data_ready_i = 1'b0;
        #3;
        chk("rst_ce", ram_ce_o, 0);
        chk("rst_inst_ready", inst_ready_o, 0);
        chk("rst_data_ready", data_ready_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        chk("rst_addr", ram_addr_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Data read alone, RAM ready in cycle 3 -> pulse in cycle 4.
        data_ce_i = 1'b1; data_addr_i = 32'h40; data_sel_i = 4'hF;
        step();
        chk("rd_ce_c1", ram_ce_o, 1);
        chk("rd_addr_c1", ram_addr_o, 32'h40);
        chk("rd_we_c1", ram_we_o, 0);
        step();
        step();
        chk("rd_ready_early", data_ready_o, 0);
        ram_data_ready_i = 1'b1; ram_data_i = 32'hDEADBEEF;
        step();
        ram_data_ready_i = 1'b0;
        chk("rd_ready_c4", data_ready_o, 1);
        chk("rd_rdata", data_rdata_o, 32'hDEADBEEF);
        chk("rd_inst_ready", inst_ready_o, 0);
        chk("rd_ce_drop", ram_ce_o, 0);
        data_ce_i = 1'b0;
        step();
        chk("rd_no_reissue", ram_ce_o, 0);
        chk("rd_pulse_end", data_ready_o, 0);

        // RAM strobe while idle is ignored.
        ram_data_ready_i = 1'b1; ram_data_i = 32'h55555555;
        step();
        ram_data_ready_i = 1'b0;
        chk("idle_strobe_d", data_ready_o, 0);
        chk("idle_strobe_i", inst_ready_o, 0);

        // Simultaneous requests: data first, inst granted in data's ready cycle.
        inst_req_i = 1'b1; inst_addr_i = 32'h100;
        data_ce_i = 1'b1; data_addr_i = 32'h200;
        step();
        chk("sim_addr_d", ram_addr_o, 32'h200);
        ram_data_ready_i = 1'b1; ram_data_i = 32'hA5A5A5A5;
        step();
        ram_data_ready_i = 1'b0;
        chk("sim_dready", data_ready_o, 1);
        chk("sim_drdata", data_rdata_o, 32'hA5A5A5A5);
        chk("sim_ce_gap", ram_ce_o, 0);
        data_ce_i = 1'b0;
        step();
        chk("sim_ce_i", ram_ce_o, 1);
        chk("sim_addr_i", ram_addr_o, 32'h100);
        chk("sim_sel_i", ram_sel_o, 4'hF);
        chk("sim_we_i", ram_we_o, 0);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h13579BDF;
        step();
        ram_data_ready_i = 1'b0;
        chk("sim_iready", inst_ready_o, 1);
        chk("sim_idata", inst_data_o, 32'h13579BDF);
        chk("sim_dready_off", data_ready_o, 0);
        inst_req_i = 1'b0;
        step();
        chk("sim_idle", ram_ce_o, 0);

        // Starvation: inst withdrawn during data ready cycles so data wins twice, then inst.
        inst_req_i = 1'b1; inst_addr_i = 32'h300;
        data_ce_i = 1'b1; data_addr_i = 32'h400;
        step();
        chk("stv_g1_d", ram_addr_o, 32'h400);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h1;
        inst_req_i = 1'b0;
        step();
        ram_data_ready_i = 1'b0;
        chk("stv_g1_ready", data_ready_o, 1);
        step();
        chk("stv_gap", ram_ce_o, 0);
        inst_req_i = 1'b1; data_addr_i = 32'h404;
        step();
        chk("stv_g2_d", ram_addr_o, 32'h404);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h2;
        inst_req_i = 1'b0;
        step();
        ram_data_ready_i = 1'b0;
        step();
        inst_req_i = 1'b1; data_addr_i = 32'h408;
        step();
        chk("stv_g3_i", ram_addr_o, 32'h300);
        chk("stv_g3_sel", ram_sel_o, 4'hF);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h3;
        step();
        ram_data_ready_i = 1'b0;
        chk("stv_g3_ready", inst_ready_o, 1);
        inst_req_i = 1'b0;
        step();
        chk("stv_g4_d", ram_addr_o, 32'h408);
        chk("stv_g4_ce", ram_ce_o, 1);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h0BADF00D;
        step();
        ram_data_ready_i = 1'b0;
        chk("stv_g4_rdata", data_rdata_o, 32'h0BADF00D);
        data_ce_i = 1'b0;
        step();

        // Write: rdata keeps its previous value.
        data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'b0011;
        data_addr_i = 32'h80; data_wdata_i = 32'h1234;
        step();
        chk("wr_we", ram_we_o, 1);
        chk("wr_sel", ram_sel_o, 4'b0011);
        chk("wr_wdata", ram_data_o, 32'h1234);
        chk("wr_addr", ram_addr_o, 32'h80);
        ram_data_ready_i = 1'b1; ram_data_i = 32'hFFFFFFFF;
        step();
        ram_data_ready_i = 1'b0;
        chk("wr_ready", data_ready_o, 1);
        chk("wr_rdata_kept", data_rdata_o, 32'h0BADF00D);
        data_ce_i = 1'b0; data_we_i = 1'b0; data_sel_i = 4'hF;
        step();

        // Timeout after 8 grant cycles, then an inst fetch is served normally.
        data_ce_i = 1'b1; data_addr_i = 32'h90;
        for (int i = 0; i < 8; i++) step();
        chk("tmo_ce_c8", ram_ce_o, 1);
        chk("tmo_err_c8", bus_err_o, 0);
        step();
        chk("tmo_err", bus_err_o, 1);
        chk("tmo_dready", data_ready_o, 1);
        chk("tmo_rdata", data_rdata_o, 0);
        chk("tmo_ce_drop", ram_ce_o, 0);
        data_ce_i = 1'b0;
        inst_req_i = 1'b1; inst_addr_i = 32'h500;
        step();
        chk("tmo_err_pulse", bus_err_o, 0);
        chk("tmo_i_addr", ram_addr_o, 32'h500);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h600D600D;
        step();
        ram_data_ready_i = 1'b0;
        chk("tmo_i_ready", inst_ready_o, 1);
        chk("tmo_i_data", inst_data_o, 32'h600D600D);
        inst_req_i = 1'b0;
        step();

        // Ready on the expiry cycle: normal completion, no bus error.
        data_ce_i = 1'b1; data_addr_i = 32'h94;
        for (int i = 0; i < 8; i++) step();
        ram_data_ready_i = 1'b1; ram_data_i = 32'h77;
        step();
        ram_data_ready_i = 1'b0;
        chk("edge_ready", data_ready_o, 1);
        chk("edge_rdata", data_rdata_o, 32'h77);
        chk("edge_no_err", bus_err_o, 0);
        data_ce_i = 1'b0;
        step();

        // Reset during an inst grant.
        inst_req_i = 1'b1; inst_addr_i = 32'h700;
        step();
        chk("mrst_ce_pre", ram_ce_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_ce", ram_ce_o, 0);
        chk("mrst_addr", ram_addr_o, 0);
        chk("mrst_sel", ram_sel_o, 0);
        chk("mrst_drdata", data_rdata_o, 0);
        chk("mrst_idata", inst_data_o, 0);
        inst_req_i = 1'b0;
        ram_data_ready_i = 1'b1; ram_data_i = 32'h99;
        step();
        chk("mrst_no_ready", inst_ready_o, 0);
        ram_data_ready_i = 1'b0;
        rst = 1'b1;
        data_ce_i = 1'b1; data_addr_i = 32'h44;
        step();
        chk("post_ce", ram_ce_o, 1);
        chk("post_addr", ram_addr_o, 32'h44);
        ram_data_ready_i = 1'b1; ram_data_i = 32'h11112222;
        step();
        ram_data_ready_i = 1'b0;
        chk("post_ready", data_ready_o, 1);
        chk("post_rdata", data_rdata_o, 32'h11112222);
        data_ce_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
